// File: rtl/uart_host.sv
`timescale 1ns/1ps
// uart_host: bus initiator that drives a memory-mapped UART for a client
// with no CPU. Transmit bytes are polled out through TX_RDY/TX_DAT and
// received bytes are polled in through RX_RDY/RX_DAT. Each direction has
// a one-byte holding register and a valid/ready handshake on the client side.
module uart_host #(
  parameter int BACKOFF = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_en,
  output logic       o_wr,
  output logic [3:0] o_addr,
  output logic [7:0] o_data,
  input  logic [7:0] i_data,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  input  logic       i_rx_ready
);

  // UART register map
  localparam logic [3:0] ADDR_TX_RDY = 4'd0;
  localparam logic [3:0] ADDR_TX_DAT = 4'd1;
  localparam logic [3:0] ADDR_RX_RDY = 4'd2;
  localparam logic [3:0] ADDR_RX_DAT = 4'd3;

  // The backoff counter only has to hold BACKOFF-1; keep it at least one bit
  // wide so the design still elaborates when backoff is disabled.
  localparam bit HAS_BACKOFF = (BACKOFF > 0);
  localparam int CNT_W = (BACKOFF > 2) ? $clog2(BACKOFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = HAS_BACKOFF ? CNT_W'(BACKOFF - 1) : '0;

  typedef enum logic [3:0] {
    IDLE,
    TX_POLL,
    TX_CHK,
    TX_WRITE,
    RX_POLL,
    RX_CHK,
    RX_READ,
    RX_LATCH,
    WAIT
  } state_t;

  state_t           state_q, state_d;
  logic             tx_full_q, tx_full_d;
  logic [7:0]       tx_buf_q, tx_buf_d;
  logic             rx_full_q, rx_full_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             prio_rx_q, prio_rx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             wr_q, wr_d;
  logic [3:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;

  logic tx_accept;
  logic rx_consume;
  logic tx_pending;
  logic rx_pending;

  // Ready is forced low while reset is held so the client sees a quiet
  // interface until the block is actually running.
  assign o_tx_ready = i_rst_n & ~tx_full_q;
  assign o_rx_valid = rx_full_q;
  assign o_rx_data  = rx_data_q;

  assign o_en   = en_q;
  assign o_wr   = wr_q;
  assign o_addr = addr_q;
  assign o_data = data_q;

  assign tx_accept  = i_tx_valid & o_tx_ready;
  assign rx_consume = rx_full_q & i_rx_ready;
  assign tx_pending = tx_full_q;
  assign rx_pending = ~rx_full_q;

  // Transmit holding register: filled by the client, emptied by the write strobe.
  always_comb begin
    tx_full_d = tx_full_q;
    tx_buf_d  = tx_buf_q;
    if (tx_accept) begin
      tx_full_d = 1'b1;
      tx_buf_d  = i_tx_data;
    end else if (state_q == TX_WRITE) begin
      tx_full_d = 1'b0;
    end
  end

  // Receive output register: filled from RX_DAT read data, emptied by the client.
  always_comb begin
    rx_full_d = rx_full_q;
    rx_data_d = rx_data_q;
    if (state_q == RX_LATCH) begin
      rx_full_d = 1'b1;
      rx_data_d = i_data;
    end else if (rx_consume) begin
      rx_full_d = 1'b0;
    end
  end

  // Sequencer: picks a direction in IDLE, then walks poll/check/access.
  // A failed poll either returns to IDLE or idles in WAIT for BACKOFF cycles.
  always_comb begin
    state_d   = state_q;
    prio_rx_d = prio_rx_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (tx_pending && rx_pending) begin
          state_d   = prio_rx_q ? RX_POLL : TX_POLL;
          prio_rx_d = ~prio_rx_q;
        end else if (tx_pending) begin
          state_d = TX_POLL;
        end else if (rx_pending) begin
          state_d = RX_POLL;
        end
      end
      TX_POLL: state_d = TX_CHK;
      TX_CHK: begin
        if (i_data[0]) begin
          state_d = TX_WRITE;
        end else if (HAS_BACKOFF) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      TX_WRITE: state_d = IDLE;
      RX_POLL:  state_d = RX_CHK;
      RX_CHK: begin
        if (i_data[0]) begin
          state_d = RX_READ;
        end else if (HAS_BACKOFF) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      RX_READ:  state_d = RX_LATCH;
      RX_LATCH: state_d = IDLE;
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are a pure function of the state being entered, so once
  // registered they track the state register exactly and never glitch.
  // Strobe states are always separated by a check or IDLE state.
  always_comb begin
    en_d   = 1'b0;
    wr_d   = 1'b0;
    addr_d = '0;
    data_d = '0;
    case (state_d)
      TX_POLL: begin
        en_d   = 1'b1;
        addr_d = ADDR_TX_RDY;
      end
      TX_WRITE: begin
        en_d   = 1'b1;
        wr_d   = 1'b1;
        addr_d = ADDR_TX_DAT;
        data_d = tx_buf_q;
      end
      RX_POLL: begin
        en_d   = 1'b1;
        addr_d = ADDR_RX_RDY;
      end
      RX_READ: begin
        en_d   = 1'b1;
        addr_d = ADDR_RX_DAT;
      end
      default: begin
        en_d   = 1'b0;
      end
    endcase
  end

  // All state; reset abandons any transaction and drops buffered bytes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      tx_full_q <= 1'b0;
      tx_buf_q  <= '0;
      rx_full_q <= 1'b0;
      rx_data_q <= '0;
      prio_rx_q <= 1'b1;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      tx_full_q <= tx_full_d;
      tx_buf_q  <= tx_buf_d;
      rx_full_q <= rx_full_d;
      rx_data_q <= rx_data_d;
      prio_rx_q <= prio_rx_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_uart_host.sv
`timescale 1ns/1ps
// Testbench for uart_host: a register-level UART model answers the bus,
// directed steps cover reset, latency, backoff, stalling and alternation,
// and a final randomized pass compares byte streams in both directions.
module tb_uart_host;

  logic       i_clk;
  logic       i_rst_n;
  logic       o_en;
  logic       o_wr;
  logic [3:0] o_addr;
  logic [7:0] o_data;
  logic [7:0] i_data = 8'h00;
  logic       i_tx_valid;
  logic [7:0] i_tx_data;
  logic       o_tx_ready;
  logic       o_rx_valid;
  logic [7:0] o_rx_data;
  logic       i_rx_ready;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus-side controls for the UART model (written only by the main initial)
  int         txFailUntil = 0;
  bit         randomMode = 1'b0;
  int         rxSrcCount = 0;
  logic [7:0] rxSrc [0:63];

  // UART model / monitor state (written only by the model always block)
  int         cycleNo = 0;
  int         txRdyReads = 0;
  int         rxRdIdx = 0;
  int         pollTx = 0;
  int         pollRx = 0;
  int         readRx = 0;
  int         writeTx = 0;
  int         lastRxPoll = 0;
  int         backToBack = 0;
  int         underflow = 0;
  int         holdErr = 0;
  int         txLogCount = 0;
  int         svcCount = 0;
  int         rxGotCount = 0;
  logic       prevEn = 1'b0;
  logic       prevHeld = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic [7:0] txLog [0:63];
  logic [7:0] svcLog [0:63];
  logic [7:0] rxGot [0:63];

  uart_host #(.BACKOFF(2)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .o_en       (o_en),
    .o_wr       (o_wr),
    .o_addr     (o_addr),
    .o_data     (o_data),
    .i_data     (i_data),
    .i_tx_valid (i_tx_valid),
    .i_tx_data  (i_tx_data),
    .o_tx_ready (o_tx_ready),
    .o_rx_valid (o_rx_valid),
    .o_rx_data  (o_rx_data),
    .i_rx_ready (i_rx_ready)
  );

  // 100 MHz clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Hard stop in case a step hangs despite its own bounds
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  // UART register model plus bus and client-side monitors
  always @(posedge i_clk) begin
    cycleNo <= cycleNo + 1;
    prevEn  <= o_en;
    if (o_en && prevEn) backToBack <= backToBack + 1;
    if (o_en && !o_wr) begin
      case (o_addr)
        4'd0: begin
          pollTx     <= pollTx + 1;
          txRdyReads <= txRdyReads + 1;
          if (txRdyReads < txFailUntil) i_data <= 8'h00;
          else if (randomMode)          i_data <= 8'($urandom);
          else                          i_data <= 8'hFF;
        end
        4'd2: begin
          pollRx     <= pollRx + 1;
          lastRxPoll <= cycleNo;
          if (rxRdIdx < rxSrcCount && (!randomMode || $urandom_range(0, 1) == 1))
            i_data <= 8'hFF;
          else
            i_data <= 8'h00;
        end
        4'd3: begin
          readRx <= readRx + 1;
          if (svcCount < 64) svcLog[svcCount] <= 8'h52;
          svcCount <= svcCount + 1;
          if (rxRdIdx < rxSrcCount) begin
            i_data  <= rxSrc[rxRdIdx];
            rxRdIdx <= rxRdIdx + 1;
          end else begin
            i_data    <= 8'hEE;
            underflow <= underflow + 1;
          end
        end
        default: i_data <= 8'h00;
      endcase
    end
    if (o_en && o_wr) begin
      writeTx <= writeTx + 1;
      if (o_addr == 4'd1) begin
        if (txLogCount < 64) txLog[txLogCount] <= o_data;
        txLogCount <= txLogCount + 1;
        if (svcCount < 64) svcLog[svcCount] <= 8'h54;
        svcCount <= svcCount + 1;
      end
    end
    if (o_rx_valid && i_rx_ready) begin
      if (rxGotCount < 64) rxGot[rxGotCount] <= o_rx_data;
      rxGotCount <= rxGotCount + 1;
    end
    prevHeld <= o_rx_valid && !i_rx_ready;
    prevData <= o_rx_data;
    if (prevHeld && o_rx_valid && o_rx_data != prevData) holdErr <= holdErr + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic txValid, input logic [7:0] txData, input logic rxReady);
    i_tx_valid = txValid;
    i_tx_data  = txData;
    i_rx_ready = rxReady;
  endtask

  // Offer one byte, hold it until accepted; called and returns at a negedge
  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    i_tx_valid = 1'b1;
    i_tx_data  = b;
    while (!o_tx_ready && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput("txHandshake", 32'(n < 1000), 32'd1);
    @(negedge i_clk);
  endtask

  task automatic waitRxValid(input string tag);
    int n;
    n = 0;
    while (!o_rx_valid && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput(tag, 32'(n < 100), 32'd1);
  endtask

  initial begin
    logic [14:0] expSeq [1:5];
    logic [20:1] enTrace;
    logic [20:1] expEn;
    logic [7:0]  txExp [0:11];
    int snap;
    int writeBase;
    int pollBase;
    int svcBase;
    int txBase;
    int rxGotBase;
    int rxSrcBase;
    int errs;
    int n;

    // ---- Reset state ----
    i_rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge i_clk);
    checkOutput("resetBus", {o_en, o_wr, o_addr, o_data}, 14'h0);
    checkOutput("resetTxReadyHeld", o_tx_ready, 1'b0);
    checkOutput("resetRxValid", o_rx_valid, 1'b0);
    i_rst_n = 1'b1;
    #1;
    checkOutput("releaseTxReady", o_tx_ready, 1'b1);
    checkOutput("releaseRxValid", o_rx_valid, 1'b0);
    @(negedge i_clk);

    // ---- RX 0x5A held while the client stalls ----
    rxSrc[0]   = 8'h5A;
    rxSrcCount = 1;
    waitRxValid("rxArrive");
    checkOutput("rxLatency", cycleNo - lastRxPoll, 4);
    checkOutput("rxData", o_rx_data, 8'h5A);
    snap = pollTx + pollRx + readRx + writeTx;
    repeat (20) @(negedge i_clk);
    checkOutput("rxStallNoStrobes", pollTx + pollRx + readRx + writeTx, snap);
    checkOutput("rxStallValid", o_rx_valid, 1'b1);
    checkOutput("rxStallData", o_rx_data, 8'h5A);
    i_rx_ready = 1'b1;
    @(negedge i_clk);
    i_rx_ready = 1'b0;
    checkOutput("rxConsumedValid", o_rx_valid, 1'b0);
    checkOutput("rxConsumedCount", rxGotCount, 1);
    checkOutput("rxConsumedByte", rxGot[0], 8'h5A);

    // ---- TX 0x41 latency with the RX side parked full ----
    rxSrc[1]   = 8'h77;
    rxSrcCount = 2;
    waitRxValid("rxPark");
    checkOutput("rxParkData", o_rx_data, 8'h77);
    repeat (3) @(negedge i_clk);
    checkOutput("txReadyBefore", o_tx_ready, 1'b1);
    expSeq[1] = {1'b0, 1'b0, 4'd0, 8'h00, 1'b0};
    expSeq[2] = {1'b1, 1'b0, 4'd0, 8'h00, 1'b0};
    expSeq[3] = {1'b0, 1'b0, 4'd0, 8'h00, 1'b0};
    expSeq[4] = {1'b1, 1'b1, 4'd1, 8'h41, 1'b0};
    expSeq[5] = {1'b0, 1'b0, 4'd0, 8'h00, 1'b1};
    applyStimulus(1'b1, 8'h41, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge i_clk);
      if (i == 1) i_tx_valid = 1'b0;
      checkOutput($sformatf("txSeqCycle%0d", i), {o_en, o_wr, o_addr, o_data, o_tx_ready}, expSeq[i]);
    end
    checkOutput("txByte41", txLog[txLogCount - 1], 8'h41);

    // ---- TX 0x42 with three not-ready polls and BACKOFF=2 ----
    txFailUntil = txRdyReads + 3;
    pollBase    = pollTx;
    writeBase   = writeTx;
    applyStimulus(1'b1, 8'h42, 1'b0);
    enTrace = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge i_clk);
      if (i == 1) i_tx_valid = 1'b0;
      enTrace[i] = o_en;
    end
    expEn     = '0;
    expEn[2]  = 1'b1;
    expEn[7]  = 1'b1;
    expEn[12] = 1'b1;
    expEn[17] = 1'b1;
    expEn[19] = 1'b1;
    checkOutput("backoffStrobeTrace", enTrace, expEn);
    checkOutput("backoffPolls", pollTx - pollBase, 4);
    checkOutput("backoffWrites", writeTx - writeBase, 1);
    checkOutput("backoffByte", txLog[txLogCount - 1], 8'h42);
    checkOutput("backoffTxReady", o_tx_ready, 1'b1);

    // ---- Reset in the middle of a TX_DAT write ----
    applyStimulus(1'b1, 8'h99, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge i_clk);
      if (i == 1) i_tx_valid = 1'b0;
    end
    checkOutput("midWriteStrobe", {o_en, o_wr, o_addr}, {1'b1, 1'b1, 4'd1});
    writeBase = writeTx;
    #1;
    i_rst_n = 1'b0;
    #1;
    checkOutput("midWriteResetBus", {o_en, o_wr, o_addr, o_data}, 14'h0);
    checkOutput("midWriteResetRx", o_rx_valid, 1'b0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    checkOutput("midWriteReleaseTxReady", o_tx_ready, 1'b1);
    checkOutput("midWriteReleaseRxValid", o_rx_valid, 1'b0);
    repeat (30) @(negedge i_clk);
    checkOutput("noStaleWrite", writeTx - writeBase, 0);

    // ---- Both directions pending: services alternate RX,TX ----
    svcBase   = svcCount;
    txBase    = txLogCount;
    rxGotBase = rxGotCount;
    for (int j = 0; j < 4; j++) rxSrc[2 + j] = 8'hA0 + 8'(j);
    rxSrcCount = 6;
    i_rx_ready = 1'b1;
    for (int j = 1; j <= 4; j++) sendByte(8'(j));
    i_tx_valid = 1'b0;
    n = 0;
    while ((txLogCount - txBase < 4 || rxGotCount - rxGotBase < 4) && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput("altComplete", 32'(n < 300), 32'd1);
    repeat (20) @(negedge i_clk);
    checkOutput("altServiceCount", svcCount - svcBase, 8);
    for (int j = 0; j < 8; j++)
      checkOutput($sformatf("altOrder%0d", j), svcLog[svcBase + j], (j % 2 == 0) ? 8'h52 : 8'h54);
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("altTx%0d", j), txLog[txBase + j], 8'(j + 1));
      checkOutput($sformatf("altRx%0d", j), rxGot[rxGotBase + j], 8'hA0 + 8'(j));
    end

    // ---- Random client stalls against random device readiness ----
    randomMode = 1'b1;
    txBase     = txLogCount;
    rxGotBase  = rxGotCount;
    rxSrcBase  = rxSrcCount;
    for (int j = 0; j < 12; j++) begin
      rxSrc[rxSrcBase + j] = 8'($urandom);
      txExp[j]             = 8'($urandom);
    end
    rxSrcCount = rxSrcBase + 12;
    fork
      begin
        for (int j = 0; j < 12; j++) begin
          i_tx_valid = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge i_clk);
          sendByte(txExp[j]);
        end
        i_tx_valid = 1'b0;
      end
      begin
        int k;
        k = 0;
        while (rxGotCount - rxGotBase < 12 && k < 4000) begin
          @(negedge i_clk);
          i_rx_ready = 1'($urandom_range(0, 1));
          k++;
        end
        i_rx_ready = 1'b0;
      end
    join
    n = 0;
    while (txLogCount - txBase < 12 && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    repeat (20) @(negedge i_clk);
    checkOutput("rndTxCount", txLogCount - txBase, 12);
    checkOutput("rndRxCount", rxGotCount - rxGotBase, 12);
    errs = 0;
    for (int j = 0; j < 12; j++) if (txLog[txBase + j] !== txExp[j]) errs++;
    checkOutput("rndTxStream", errs, 0);
    errs = 0;
    for (int j = 0; j < 12; j++) if (rxGot[rxGotBase + j] !== rxSrc[rxSrcBase + j]) errs++;
    checkOutput("rndRxStream", errs, 0);
    checkOutput("backToBackStrobes", backToBack, 0);
    checkOutput("rxDatUnderflow", underflow, 0);
    checkOutput("rxDataHeldStable", holdErr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
